// File: rtl/pcpi_div_pkg.sv
// Shared definitions for the PCPI divide/remainder co-processor.
// Holds the instruction-match constants, the operation and FSM state
// enums, and small helpers for decoding the operation.
package pcpi_div_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Encoded as funct3[1:0] of the 1xx group.
  typedef enum logic [1:0] {
    OpDiv  = 2'b00,
    OpDivu = 2'b01,
    OpRem  = 2'b10,
    OpRemu = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } div_state_e;

  function automatic logic op_is_signed(div_op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/pcpi_div_step.sv
// One combinational restoring-division step.
// Ports:
//   rem_i/rem_o  partial remainder (never wider than XLEN bits)
//   div_i/div_o  shifted divisor, 2*XLEN-1 bits, shifted right one per step
//   quo_i/quo_o  quotient being built
//   msk_i/msk_o  one-hot quotient bit retired by this step
module pcpi_div_step
  import pcpi_div_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]   rem_i,
  input  logic [2*XLEN-2:0] div_i,
  input  logic [XLEN-1:0]   quo_i,
  input  logic [XLEN-1:0]   msk_i,
  output logic [XLEN-1:0]   rem_o,
  output logic [2*XLEN-2:0] div_o,
  output logic [XLEN-1:0]   quo_o,
  output logic [XLEN-1:0]   msk_o
);

  logic fits;

  always_comb begin
    fits  = div_i <= {{(XLEN - 1){1'b0}}, rem_i};
    // When the divisor fits it is below 2^XLEN, so its low half is exact.
    rem_o = fits ? rem_i - div_i[XLEN-1:0] : rem_i;
    quo_o = fits ? quo_i | msk_i : quo_i;
    div_o = div_i >> 1;
    msk_o = msk_i >> 1;
  end

endmodule

// File: rtl/pcpi_div_radix.sv
// PCPI divide/remainder co-processor for DIV, DIVU, REM and REMU.
// Retires BITS_PER_CYCLE quotient bits per cycle via a chain of
// pcpi_div_step instances; XLEN/BITS_PER_CYCLE iterations per instruction.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   pcpi_valid/insn    instruction offered by the core
//   pcpi_rs1/rs2       dividend / divisor
//   pcpi_wr/ready      one-cycle result strobe
//   pcpi_rd            result, zero outside the strobe
//   pcpi_wait          instruction claimed, result pending
// Build option: define PCPI_DIV_EARLY_EXIT_EN to let divide-by-zero and
// signed overflow skip the iteration phase.
module pcpi_div_radix
  import pcpi_div_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            pcpi_valid,
  input  logic [31:0]     pcpi_insn,
  input  logic [XLEN-1:0] pcpi_rs1,
  input  logic [XLEN-1:0] pcpi_rs2,
  output logic            pcpi_wr,
  output logic [XLEN-1:0] pcpi_rd,
  output logic            pcpi_wait,
  output logic            pcpi_ready
);

  localparam int unsigned Iters = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CntW  = $clog2(Iters + 1);
  localparam int unsigned DW    = 2 * XLEN - 1;

  div_state_e state_q, state_d;

  div_op_e         op_q;
  logic [XLEN-1:0] rs1_q, rem_q, quo_q, msk_q;
  logic [DW-1:0]   div_q;
  logic [CntW-1:0] cnt_q;
  logic            neg_quo_q, neg_rem_q, div0_q, ovf_q;

  // Decode
  logic            insn_match, in_signed, rs1_neg, rs2_neg, in_div0, in_ovf;
  logic            accept, early_exit;
  div_op_e         insn_op;
  logic [XLEN-1:0] abs1, abs2;
  logic            unused_insn;

  assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};
  assign insn_match  = (pcpi_insn[6:0] == OPCODE_OP) && (pcpi_insn[31:25] == FUNCT7_MULDIV) &&
                       pcpi_insn[14];
  assign insn_op     = div_op_e'(pcpi_insn[13:12]);
  assign in_signed   = op_is_signed(insn_op);
  assign rs1_neg     = in_signed & pcpi_rs1[XLEN-1];
  assign rs2_neg     = in_signed & pcpi_rs2[XLEN-1];
  assign abs1        = rs1_neg ? -pcpi_rs1 : pcpi_rs1;
  assign abs2        = rs2_neg ? -pcpi_rs2 : pcpi_rs2;
  assign in_div0     = (pcpi_rs2 == '0);
  assign in_ovf      = in_signed & (pcpi_rs1 == {1'b1, {(XLEN - 1){1'b0}}}) & (&pcpi_rs2);
  assign accept      = (state_q == StIdle) && pcpi_valid && insn_match && !pcpi_ready;

`ifdef PCPI_DIV_EARLY_EXIT_EN
  assign early_exit = in_div0 | in_ovf;
`else
  assign early_exit = 1'b0;
`endif

  // Step chain
  logic [BITS_PER_CYCLE:0][XLEN-1:0] rem_c, quo_c, msk_c;
  logic [BITS_PER_CYCLE:0][DW-1:0]   div_c;

  assign rem_c[0] = rem_q;
  assign div_c[0] = div_q;
  assign quo_c[0] = quo_q;
  assign msk_c[0] = msk_q;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    pcpi_div_step #(
      .XLEN(XLEN)
    ) u_step (
      .rem_i(rem_c[i]),
      .div_i(div_c[i]),
      .quo_i(quo_c[i]),
      .msk_i(msk_c[i]),
      .rem_o(rem_c[i+1]),
      .div_o(div_c[i+1]),
      .quo_o(quo_c[i+1]),
      .msk_o(msk_c[i+1])
    );
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = early_exit ? StDone : StCalc;
      StCalc: begin
        if (!pcpi_valid) begin
          state_d = StIdle;
        end else if (cnt_q == CntW'(1)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q      <= OpDiv;
      rs1_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      quo_q     <= '0;
      msk_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (accept) begin
      op_q      <= insn_op;
      rs1_q     <= pcpi_rs1;
      rem_q     <= abs1;
      div_q     <= {abs2, {(XLEN - 1){1'b0}}};
      quo_q     <= '0;
      msk_q     <= {1'b1, {(XLEN - 1){1'b0}}};
      cnt_q     <= CntW'(Iters);
      neg_quo_q <= in_signed & (pcpi_rs1[XLEN-1] ^ pcpi_rs2[XLEN-1]) & ~in_div0;
      neg_rem_q <= rs1_neg;
      div0_q    <= in_div0;
      ovf_q     <= in_ovf;
    end else if (state_q == StCalc) begin
      rem_q <= rem_c[BITS_PER_CYCLE];
      div_q <= div_c[BITS_PER_CYCLE];
      quo_q <= quo_c[BITS_PER_CYCLE];
      msk_q <= msk_c[BITS_PER_CYCLE];
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  // Outputs: result selection from the registered quotient/remainder and flags
  logic [XLEN-1:0] quo_res, rem_res;

  always_comb begin
    quo_res = neg_quo_q ? -quo_q : quo_q;
    rem_res = neg_rem_q ? -rem_q : rem_q;
    if (div0_q) begin
      quo_res = '1;
      rem_res = rs1_q;
    end else if (ovf_q) begin
      quo_res = rs1_q;
      rem_res = '0;
    end
    pcpi_wait  = (state_q == StCalc);
    pcpi_ready = (state_q == StDone);
    pcpi_wr    = pcpi_ready;
    pcpi_rd    = pcpi_ready ? (op_is_rem(op_q) ? rem_res : quo_res) : '0;
  end

endmodule

// File: tb/tb_pcpi_div_radix.sv
// Self-checking bench for pcpi_div_radix: one instance with one quotient bit
// per cycle, one with four. Expected results are queued when an instruction
// is driven and compared when the matching pcpi_ready strobe appears.
module tb_pcpi_div_radix;

  localparam logic [2:0] F3Div  = 3'b100;
  localparam logic [2:0] F3Divu = 3'b101;
  localparam logic [2:0] F3Rem  = 3'b110;
  localparam logic [2:0] F3Remu = 3'b111;

`ifdef PCPI_DIV_EARLY_EXIT_EN
  localparam bit Early = 1'b1;
`else
  localparam bit Early = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn, valid, valid4;
  logic [31:0] insn, rs1, rs2;
  logic        wr1, wait1, ready1, wr4, wait4, ready4;
  logic [31:0] rd1, rd4;

  always #5 clk = ~clk;

  pcpi_div_radix #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .resetn(resetn), .pcpi_valid(valid), .pcpi_insn(insn),
    .pcpi_rs1(rs1), .pcpi_rs2(rs2), .pcpi_wr(wr1), .pcpi_rd(rd1),
    .pcpi_wait(wait1), .pcpi_ready(ready1)
  );

  pcpi_div_radix #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .resetn(resetn), .pcpi_valid(valid4), .pcpi_insn(insn),
    .pcpi_rs1(rs1), .pcpi_rs2(rs2), .pcpi_wr(wr4), .pcpi_rd(rd4),
    .pcpi_wait(wait4), .pcpi_ready(ready4)
  );

  typedef struct {
    logic [31:0] rd;
    int          cycle;
  } exp_t;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
  } vec_t;

  exp_t sb1[$];
  exp_t sb4[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rdy_cnt1 = 0;
  int   rdy_cnt4 = 0;
  bit   rd_leak = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_insn(logic [6:0] f7, logic [2:0] f3, logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
  endfunction

  // Scoreboard side: pop and compare on each result strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ready1 === 1'b1) begin
        rdy_cnt1++;
        if (sb1.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_ready dut: ready=1 with nothing pending, required 0");
        end else begin
          e = sb1.pop_front();
          check("dut rd", rd1, e.rd);
          check("dut ready_cycle", 32'(cyc), 32'(e.cycle));
          check("dut wr", 32'(wr1), 32'd1);
        end
      end
      if (ready4 === 1'b1) begin
        rdy_cnt4++;
        if (sb4.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_ready dut4: ready=1 with nothing pending, required 0");
        end else begin
          e = sb4.pop_front();
          check("dut4 rd", rd4, e.rd);
          check("dut4 ready_cycle", 32'(cyc), 32'(e.cycle));
          check("dut4 wr", 32'(wr4), 32'd1);
        end
      end
      if ((ready1 !== 1'b1 && (rd1 !== '0 || wr1 !== 1'b0)) ||
          (ready4 !== 1'b1 && (rd4 !== '0 || wr4 !== 1'b0))) rd_leak = 1'b1;
    end
  end

  // Offer one instruction and hold valid until its strobe; valid is left high
  // so a following call starts in the earliest legal cycle.
  task automatic run_op(input bit use4, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit special,
                        input string name);
    int n, lat, start, rel;
    bit wait_ok, seen, w, exp_wait;
    n   = use4 ? 8 : 32;
    lat = (special && Early) ? 1 : n + 1;
    @(posedge clk);
    #1;
    insn = mk_insn(7'b0000001, f3, 7'b0110011);
    rs1  = a;
    rs2  = b;
    if (use4) valid4 = 1'b1;
    else valid = 1'b1;
    start = cyc;
    if (use4) sb4.push_back('{exp, start + lat});
    else sb1.push_back('{exp, start + lat});
    wait_ok = 1'b1;
    seen    = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      rel      = cyc - start;
      exp_wait = !(special && Early) && rel >= 1 && rel <= n;
      w        = use4 ? wait4 : wait1;
      if (w !== exp_wait) wait_ok = 1'b0;
      seen = use4 ? ready4 : ready1;
    end
    check({name, " wait_profile"}, 32'(wait_ok), 32'd1);
    if (!seen) check({name, " timeout"}, 32'(seen), 32'd1);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    valid  = 1'b0;
    valid4 = 1'b0;
  endtask

  task automatic mismatch(input logic [31:0] word, input string name);
    bit quiet;
    @(posedge clk);
    #1;
    insn  = word;
    rs1   = 32'd100;
    rs2   = 32'd7;
    valid = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (wait1 !== 1'b0 || ready1 !== 1'b0) quiet = 1'b0;
    end
    check({name, " ignored"}, 32'(quiet), 32'd1);
    idle();
  endtask

  vec_t vecs[16];

  initial begin
    int base;
    resetn = 1'b1;
    valid  = 1'b0;
    valid4 = 1'b0;
    insn   = '0;
    rs1    = '0;
    rs2    = '0;
    #2 resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset wait", 32'(wait1), 32'd0);
    check("reset ready", 32'(ready1), 32'd0);
    check("reset wr", 32'(wr1), 32'd0);
    check("reset rd", rd1, 32'd0);
    check("reset dut4 ready", 32'(ready4), 32'd0);
    resetn = 1'b1;

    vecs[0]  = '{F3Div,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0};
    vecs[1]  = '{F3Rem,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{F3Remu, 32'd100,      32'd7,        32'd2,        1'b0};
    vecs[3]  = '{F3Divu, 32'd100,      32'd7,        32'd14,       1'b0};
    vecs[4]  = '{F3Div,  32'd5,        32'd0,        32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{F3Rem,  32'd5,        32'd0,        32'd5,        1'b1};
    vecs[6]  = '{F3Div,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[7]  = '{F3Rem,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[8]  = '{F3Divu, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[9]  = '{F3Remu, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0};
    vecs[10] = '{F3Div,  32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0};
    vecs[11] = '{F3Rem,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 1'b0};
    vecs[12] = '{F3Rem,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1'b1};
    vecs[13] = '{F3Divu, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 1'b1};
    vecs[14] = '{F3Remu, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 1'b0};
    vecs[15] = '{F3Div,  32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       1'b0};

    // Back-to-back table: each accept lands in cycle N+2 of the previous op.
    for (int i = 0; i < 16; i++) begin
      run_op(1'b0, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].special, "vec");
    end
    idle();

    // Random operands, expected values from the language's own / and %.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b, e;
      logic [2:0]  f3;
      a  = $urandom;
      b  = (i % 2 == 1) ? $urandom : $urandom_range(1, 1000);
      if (b == '0) b = 32'd1;
      if (a == 32'h80000000) a = 32'd1;
      f3 = F3Div + 3'(i % 4);
      case (f3)
        F3Div:   e = $signed(a) / $signed(b);
        F3Divu:  e = a / b;
        F3Rem:   e = $signed(a) % $signed(b);
        default: e = a % b;
      endcase
      run_op(1'b0, f3, a, b, e, 1'b0, "rand");
    end
    idle();

    // Four bits per cycle
    run_op(1'b1, F3Divu, 32'd100, 32'd7, 32'd14, 1'b0, "r4 divu");
    run_op(1'b1, F3Rem, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, "r4 rem");
    run_op(1'b1, F3Div, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1, "r4 div0");
    idle();

    // Abort: valid dropped in cycle 10
    @(posedge clk);
    #1;
    insn  = mk_insn(7'b0000001, F3Divu, 7'b0110011);
    rs1   = 32'd1000;
    rs2   = 32'd3;
    valid = 1'b1;
    base  = rdy_cnt1;
    repeat (10) @(posedge clk);
    #1;
    valid = 1'b0;
    @(negedge clk);
    check("abort wait c10", 32'(wait1), 32'd1);
    @(negedge clk);
    check("abort wait c11", 32'(wait1), 32'd0);
    repeat (40) @(negedge clk);
    check("abort no ready", 32'(rdy_cnt1 - base), 32'd0);
    run_op(1'b0, F3Divu, 32'd9, 32'd3, 32'd3, 1'b0, "after abort");
    idle();

    // Non-matching instructions
    mismatch(mk_insn(7'b0000001, 3'b000, 7'b0110011), "mul");
    mismatch(mk_insn(7'b0000000, F3Div, 7'b0110011), "funct7_0");
    mismatch(mk_insn(7'b0000001, F3Div, 7'b0010011), "opcode");

    // Reset mid-CALC
    @(posedge clk);
    #1;
    insn  = mk_insn(7'b0000001, F3Div, 7'b0110011);
    rs1   = 32'd1000;
    rs2   = 32'd7;
    valid = 1'b1;
    base  = rdy_cnt1;
    repeat (15) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("midreset wait", 32'(wait1), 32'd0);
    check("midreset ready", 32'(ready1), 32'd0);
    check("midreset rd", rd1, 32'd0);
    valid = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (40) @(negedge clk);
    check("midreset no ready", 32'(rdy_cnt1 - base), 32'd0);
    run_op(1'b0, F3Div, 32'd1000, 32'd7, 32'd142, 1'b0, "after reset");
    idle();

    repeat (3) @(negedge clk);
    check("sb dut drained", 32'(sb1.size()), 32'd0);
    check("sb dut4 drained", 32'(sb4.size()), 32'd0);
    check("rd/wr zero outside ready", 32'(rd_leak), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
